// File: rtl/clq_walker.sv
// rtl/clq_walker.sv - CLQ clause-list walker: literal lookup, node-chain walk, node stream out
//
// Accepts a literal from the unit-clause arbiter, presents it to the CLQ head
// lookup, then follows the CNF node chain one hop per cycle and streams each
// node to the BCP evaluator through a registered valid/ready slot.
//
// Optional feature macro: CLQ_WALKER_STATS_EN (walk/node statistics counters).
//
// Ports:
//   clk, rst_n               clock; synchronous active-high reset (1 = reset)
//   uc_in/_valid/_ready      literal input handshake
//   ucarb2clq_uc_rqst/_valid literal to CLQ head lookup
//   clq2bcp_init_ptr/_valid  head pointer from CLQ (combinational)
//   bcp2clq_cnf_idx          CLQ read index (cur_ptr)
//   clq2bcp_node_out         node at bcp2clq_cnf_idx, same cycle
//   node_out/_valid/_ready   registered node stream to evaluator
//   node_out_last            final node of the current list
//   walk_empty               one-cycle pulse: literal had no list
//   loop_err                 sticky: hop limit reached without a null next
//   walk_cnt, node_cnt       statistics (zero unless CLQ_WALKER_STATS_EN)
module clq_walker #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int LIT_W  = 8,
  parameter int NODE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LIT_W-1:0]  uc_in,
  input  logic              uc_in_valid,
  output logic              uc_in_ready,
  output logic [LIT_W-1:0]  ucarb2clq_uc_rqst,
  output logic              ucarb2clq_uc_rqst_valid,
  input  logic [PTR_W-1:0]  clq2bcp_init_ptr,
  input  logic              clq2bcp_init_ptr_valid,
  output logic [PTR_W-1:0]  bcp2clq_cnf_idx,
  input  logic [NODE_W-1:0] clq2bcp_node_out,
  output logic [NODE_W-1:0] node_out,
  output logic              node_out_valid,
  input  logic              node_out_ready,
  output logic              node_out_last,
  output logic              walk_empty,
  output logic              loop_err,
  output logic [15:0]       walk_cnt,
  output logic [15:0]       node_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WALK   = 2'd2
  } state_t;

  state_t           state;
  logic [LIT_W-1:0] lit_q;
  logic [PTR_W-1:0] cur_ptr;
  logic [PTR_W-1:0] hops;

  // The next field lives in the low bits of the node; the bit above the
  // index is the null marker.
  logic             next_null;
  logic [PTR_W-1:0] next_idx;
  logic             slot_free;
  logic             capture;
  logic             hop_limit;

  assign next_null = clq2bcp_node_out[PTR_W];
  assign next_idx  = clq2bcp_node_out[PTR_W-1:0];
  assign slot_free = !node_out_valid || node_out_ready;
  assign capture   = (state == S_WALK) && slot_free;
  assign hop_limit = (hops == PTR_W'(DEPTH - 1));

  assign uc_in_ready             = (state == S_IDLE);
  assign ucarb2clq_uc_rqst       = lit_q;
  assign ucarb2clq_uc_rqst_valid = (state == S_LOOKUP);
  assign bcp2clq_cnf_idx         = cur_ptr;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state          <= S_IDLE;
      lit_q          <= '0;
      cur_ptr        <= '0;
      hops           <= '0;
      node_out       <= '0;
      node_out_valid <= 1'b0;
      node_out_last  <= 1'b0;
      walk_empty     <= 1'b0;
      loop_err       <= 1'b0;
    end else begin
      walk_empty <= 1'b0;

      // Drain the slot; a capture below in the same cycle refills it.
      if (node_out_valid && node_out_ready) begin
        node_out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (uc_in_valid) begin
            lit_q <= uc_in;
            state <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (clq2bcp_init_ptr_valid) begin
            cur_ptr <= clq2bcp_init_ptr;
            hops    <= '0;
            state   <= S_WALK;
          end else begin
            walk_empty <= 1'b1;
            state      <= S_IDLE;
          end
        end

        S_WALK: begin
          if (capture) begin
            node_out       <= clq2bcp_node_out;
            node_out_valid <= 1'b1;
            cur_ptr        <= next_idx;
            hops           <= hops + PTR_W'(1);
            node_out_last  <= next_null || hop_limit;
            if (next_null) begin
              state <= S_IDLE;
            end else if (hop_limit) begin
              // DEPTH hops without a null: the chain must be circular.
              loop_err <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CLQ_WALKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      walk_cnt <= '0;
      node_cnt <= '0;
    end else begin
      if ((state == S_LOOKUP) && clq2bcp_init_ptr_valid && (walk_cnt != 16'hFFFF)) begin
        walk_cnt <= walk_cnt + 16'd1;
      end
      if (node_out_valid && node_out_ready && (node_cnt != 16'hFFFF)) begin
        node_cnt <= node_cnt + 16'd1;
      end
    end
  end
`else
  assign walk_cnt = 16'd0;
  assign node_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_clq_walker.sv
// tb/tb_clq_walker.sv - directed self-checking bench for clq_walker
module tb_clq_walker;

  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;
  localparam int LIT_W  = 8;
  localparam int NODE_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [LIT_W-1:0]  uc_in;
  logic              uc_in_valid;
  logic              uc_in_ready;
  logic [LIT_W-1:0]  ucarb2clq_uc_rqst;
  logic              ucarb2clq_uc_rqst_valid;
  logic [PTR_W-1:0]  clq2bcp_init_ptr;
  logic              clq2bcp_init_ptr_valid;
  logic [PTR_W-1:0]  bcp2clq_cnf_idx;
  logic [NODE_W-1:0] clq2bcp_node_out;
  logic [NODE_W-1:0] node_out;
  logic              node_out_valid;
  logic              node_out_ready;
  logic              node_out_last;
  logic              walk_empty;
  logic              loop_err;
  logic [15:0]       walk_cnt;
  logic [15:0]       node_cnt;

  logic [NODE_W-1:0] mem [DEPTH];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign clq2bcp_node_out = mem[bcp2clq_cnf_idx];

  clq_walker #(.DEPTH(DEPTH), .PTR_W(PTR_W), .LIT_W(LIT_W), .NODE_W(NODE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .uc_in(uc_in), .uc_in_valid(uc_in_valid), .uc_in_ready(uc_in_ready),
    .ucarb2clq_uc_rqst(ucarb2clq_uc_rqst), .ucarb2clq_uc_rqst_valid(ucarb2clq_uc_rqst_valid),
    .clq2bcp_init_ptr(clq2bcp_init_ptr), .clq2bcp_init_ptr_valid(clq2bcp_init_ptr_valid),
    .bcp2clq_cnf_idx(bcp2clq_cnf_idx), .clq2bcp_node_out(clq2bcp_node_out),
    .node_out(node_out), .node_out_valid(node_out_valid), .node_out_ready(node_out_ready),
    .node_out_last(node_out_last), .walk_empty(walk_empty), .loop_err(loop_err),
    .walk_cnt(walk_cnt), .node_cnt(node_cnt)
  );

  // Node layout: {11-bit payload tag, null bit, 4-bit next index}.
  function automatic logic [NODE_W-1:0] mk(input int idx, input logic nul, input int nxt);
    logic [10:0] tag;
    tag = 11'h100 + 11'(idx);
    return {tag, nul, 4'(nxt)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drives one literal; returns in cycle 1 (LOOKUP) of the walk.
  task automatic issue(input logic [LIT_W-1:0] lit, input int head, input logic hv);
    uc_in                  = lit;
    uc_in_valid            = 1'b1;
    clq2bcp_init_ptr       = 4'(head);
    clq2bcp_init_ptr_valid = hv;
    tick();
    uc_in_valid = 1'b0;
  endtask

  int nvalid, nlast, lastpos;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = mk(i, 1'b1, 0);
    rst_n = 1'b1; uc_in = '0; uc_in_valid = 1'b0; node_out_ready = 1'b1;
    clq2bcp_init_ptr = '0; clq2bcp_init_ptr_valid = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(uc_in_ready), 1);
    chk("rst_valid", 32'(node_out_valid), 0);
    chk("rst_node", 32'(node_out), 0);
    chk("rst_last", 32'(node_out_last), 0);
    chk("rst_empty", 32'(walk_empty), 0);
    chk("rst_loop", 32'(loop_err), 0);
    chk("rst_rqv", 32'(ucarb2clq_uc_rqst_valid), 0);
    chk("rst_idx", 32'(bcp2clq_cnf_idx), 0);
    chk("rst_wcnt", 32'(walk_cnt), 0);
    chk("rst_ncnt", 32'(node_cnt), 0);
    rst_n = 1'b0;

    // Walk 1: literal 5, list 3 -> 7 -> null
    mem[3] = mk(3, 1'b0, 7);
    mem[7] = mk(7, 1'b1, 0);
    issue(8'd5, 3, 1'b1);
    chk("w1_c1_rqv", 32'(ucarb2clq_uc_rqst_valid), 1);
    chk("w1_c1_rq", 32'(ucarb2clq_uc_rqst), 5);
    chk("w1_c1_rdy", 32'(uc_in_ready), 0);
    tick();
    chk("w1_c2_idx", 32'(bcp2clq_cnf_idx), 3);
    chk("w1_c2_val", 32'(node_out_valid), 0);
    tick();
    chk("w1_c3_val", 32'(node_out_valid), 1);
    chk("w1_c3_node", 32'(node_out), 32'(mk(3, 1'b0, 7)));
    chk("w1_c3_last", 32'(node_out_last), 0);
    chk("w1_c3_idx", 32'(bcp2clq_cnf_idx), 7);
    tick();
    chk("w1_c4_node", 32'(node_out), 32'(mk(7, 1'b1, 0)));
    chk("w1_c4_last", 32'(node_out_last), 1);
    chk("w1_c4_rdy", 32'(uc_in_ready), 1);
    tick();
    chk("w1_c5_val", 32'(node_out_valid), 0);

    // Empty list, negative literal
    issue(8'h85, 0, 1'b0);
    chk("em_c1_rq", 32'(ucarb2clq_uc_rqst), 32'h85);
    tick();
    chk("em_c2_pulse", 32'(walk_empty), 1);
    chk("em_c2_rdy", 32'(uc_in_ready), 1);
    chk("em_c2_val", 32'(node_out_valid), 0);
    tick();
    chk("em_c3_pulse", 32'(walk_empty), 0);
    chk("em_c3_val", 32'(node_out_valid), 0);

    // Stall on the second node of 2 -> 9 -> 12 -> null
    mem[2]  = mk(2, 1'b0, 9);
    mem[9]  = mk(9, 1'b0, 12);
    mem[12] = mk(12, 1'b1, 0);
    issue(8'd6, 2, 1'b1);
    tick(); tick();
    chk("st_c3_node", 32'(node_out), 32'(mk(2, 1'b0, 9)));
    tick();
    node_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("st_hold_node%0d", k), 32'(node_out), 32'(mk(9, 1'b0, 12)));
      chk($sformatf("st_hold_idx%0d", k), 32'(bcp2clq_cnf_idx), 12);
      chk($sformatf("st_hold_val%0d", k), 32'(node_out_valid), 1);
      tick();
    end
    node_out_ready = 1'b1;
    chk("st_rel_node", 32'(node_out), 32'(mk(9, 1'b0, 12)));
    chk("st_rel_last", 32'(node_out_last), 0);
    tick();
    chk("st_n3_node", 32'(node_out), 32'(mk(12, 1'b1, 0)));
    chk("st_n3_last", 32'(node_out_last), 1);
    chk("st_n3_rdy", 32'(uc_in_ready), 1);
    tick();
    chk("st_done_val", 32'(node_out_valid), 0);

    // Circular list 0 -> 1 -> 0
    mem[0] = mk(0, 1'b0, 1);
    mem[1] = mk(1, 1'b0, 0);
    issue(8'd9, 0, 1'b1);
    nvalid = 0; nlast = 0; lastpos = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (node_out_valid) begin
        nvalid++;
        if (node_out_last) begin
          nlast++;
          lastpos = nvalid;
        end
      end
    end
    chk("cir_count", 32'(nvalid), 16);
    chk("cir_nlast", 32'(nlast), 1);
    chk("cir_lastpos", 32'(lastpos), 16);
    chk("cir_loop", 32'(loop_err), 1);
    chk("cir_rdy", 32'(uc_in_ready), 1);

    // Reset in cycle 4 of a 6-node walk 4 -> 5 -> 6 -> 8 -> 10 -> 11
    mem[4]  = mk(4, 1'b0, 5);
    mem[5]  = mk(5, 1'b0, 6);
    mem[6]  = mk(6, 1'b0, 8);
    mem[8]  = mk(8, 1'b0, 10);
    mem[10] = mk(10, 1'b0, 11);
    mem[11] = mk(11, 1'b1, 0);
    issue(8'd11, 4, 1'b1);
    tick(); tick(); tick();
    chk("rw_c4_node", 32'(node_out), 32'(mk(5, 1'b0, 6)));
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("rw_val", 32'(node_out_valid), 0);
    chk("rw_rdy", 32'(uc_in_ready), 1);
    chk("rw_idx", 32'(bcp2clq_cnf_idx), 0);
    chk("rw_loop", 32'(loop_err), 0);
    chk("rw_wcnt", 32'(walk_cnt), 0);

    // Fresh 2-node walk after reset
    issue(8'd5, 3, 1'b1);
    tick(); tick();
    chk("fr_n1", 32'(node_out), 32'(mk(3, 1'b0, 7)));
    chk("fr_n1_val", 32'(node_out_valid), 1);
    tick();
    chk("fr_n2", 32'(node_out), 32'(mk(7, 1'b1, 0)));
    chk("fr_n2_last", 32'(node_out_last), 1);

    // 3-node walk, then statistics
    issue(8'd6, 2, 1'b1);
    tick(); tick(); tick(); tick();
    chk("s3_last_node", 32'(node_out), 32'(mk(12, 1'b1, 0)));
    tick();
`ifdef CLQ_WALKER_STATS_EN
    chk("stat_walk", 32'(walk_cnt), 2);
    chk("stat_node", 32'(node_cnt), 5);
`else
    chk("stat_walk", 32'(walk_cnt), 0);
    chk("stat_node", 32'(node_cnt), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
